// File: rtl/exc_ctrl_if.sv
// Pipeline/CP0/fetch-side signal bundle for exc_ctrl.
// master = pipeline, CP0 and fetch side; slave = exc_ctrl.
interface exc_ctrl_if;
  logic        m_valid;
  logic [31:0] m_pc;
  logic        m_bd;
  logic        m_adel_if;
  logic        m_ri;
  logic        m_ov;
  logic        m_sys;
  logic        m_bp;
  logic        m_adel_ld;
  logic        m_ades;
  logic [31:0] m_addr;
  logic        m_eret;
  logic [31:0] cp0_status;
  logic [31:0] cp0_cause;
  logic [31:0] cp0_epc;
  logic        ex_valid;
  logic [4:0]  ex_excode;
  logic        ex_bd;
  logic [31:0] ex_epc;
  logic [31:0] ex_badvaddr;
  logic        ex_eret;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  modport master (
    output m_valid, m_pc, m_bd, m_adel_if, m_ri, m_ov, m_sys, m_bp,
           m_adel_ld, m_ades, m_addr, m_eret, cp0_status, cp0_cause,
           cp0_epc, redirect_ready,
    input  ex_valid, ex_excode, ex_bd, ex_epc, ex_badvaddr, ex_eret,
           flush, redirect_valid, redirect_pc
  );

  modport slave (
    input  m_valid, m_pc, m_bd, m_adel_if, m_ri, m_ov, m_sys, m_bp,
           m_adel_ld, m_ades, m_addr, m_eret, cp0_status, cp0_cause,
           cp0_epc, redirect_ready,
    output ex_valid, ex_excode, ex_bd, ex_epc, ex_badvaddr, ex_eret,
           flush, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/exc_ctrl.sv
// MEM-stage exception/interrupt commit: priority pick, CP0 write, flush, held redirect.
// Define EXC_ERET_CHECK_EN to turn eret with status.EXL=0 into a reserved-instruction fault.
module exc_ctrl #(
  parameter logic [31:0] VEC_BEV  = 32'hBFC0_0380,
  parameter logic [31:0] VEC_NORM = 32'h8000_0180
) (
  input logic       clk,
  input logic       resetn,
  exc_ctrl_if.slave bus
);
  typedef enum logic {IDLE, REDIR} state_t;

  state_t      state;
  logic        int_pend;
  logic        hit;
  logic        take;
  logic        sel_eret;
  logic [4:0]  sel_code;
  logic [31:0] sel_badv;

  assign int_pend = bus.cp0_status[0] & ~bus.cp0_status[1] &
                    (|(bus.cp0_cause[15:8] & bus.cp0_status[15:8]));

  always_comb begin
    hit      = 1'b1;
    sel_eret = 1'b0;
    sel_code = 5'd0;
    sel_badv = 32'h0;
    if (int_pend)            sel_code = 5'd0;
    else if (bus.m_adel_if) begin
      sel_code = 5'd4;
      sel_badv = bus.m_pc;
    end
    else if (bus.m_ri)       sel_code = 5'd10;
    else if (bus.m_ov)       sel_code = 5'd12;
    else if (bus.m_sys)      sel_code = 5'd8;
    else if (bus.m_bp)       sel_code = 5'd9;
    else if (bus.m_adel_ld) begin
      sel_code = 5'd4;
      sel_badv = bus.m_addr;
    end
    else if (bus.m_ades) begin
      sel_code = 5'd5;
      sel_badv = bus.m_addr;
    end
    else if (bus.m_eret) begin
`ifdef EXC_ERET_CHECK_EN
      // eret outside exception level is illegal: fault as RI instead
      if (bus.cp0_status[1]) sel_eret = 1'b1;
      else                   sel_code = 5'd10;
`else
      sel_eret = 1'b1;
`endif
    end
    else hit = 1'b0;
  end

  // resetn gate keeps flush low while reset is held with a valid MEM input
  assign take               = resetn & (state == IDLE) & bus.m_valid & hit;
  assign bus.flush          = take | (state == REDIR);
  assign bus.redirect_valid = (state == REDIR);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= IDLE;
      bus.ex_valid    <= 1'b0;
      bus.ex_eret     <= 1'b0;
      bus.ex_bd       <= 1'b0;
      bus.ex_excode   <= 5'd0;
      bus.ex_epc      <= 32'h0;
      bus.ex_badvaddr <= 32'h0;
      bus.redirect_pc <= 32'h0;
    end else begin
      bus.ex_valid <= 1'b0;
      bus.ex_eret  <= 1'b0;
      case (state)
        IDLE: if (take) begin
          state           <= REDIR;
          bus.ex_valid    <= 1'b1;
          bus.ex_eret     <= sel_eret;
          bus.ex_excode   <= sel_code;
          bus.ex_bd       <= bus.m_bd;
          bus.ex_epc      <= bus.m_bd ? bus.m_pc - 32'd4 : bus.m_pc;
          bus.ex_badvaddr <= sel_badv;
          if (sel_eret)               bus.redirect_pc <= bus.cp0_epc;
          else if (bus.cp0_status[22]) bus.redirect_pc <= VEC_BEV;
          else                        bus.redirect_pc <= VEC_NORM;
        end
        REDIR: if (bus.redirect_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_exc_ctrl.sv
// Directed self-checking bench for exc_ctrl.
module tb_exc_ctrl;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  exc_ctrl_if bus ();
  exc_ctrl dut (.clk(clk), .resetn(resetn), .bus(bus));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_m();
    bus.m_valid = 0; bus.m_pc = 0; bus.m_bd = 0; bus.m_adel_if = 0;
    bus.m_ri = 0; bus.m_ov = 0; bus.m_sys = 0; bus.m_bp = 0;
    bus.m_adel_ld = 0; bus.m_ades = 0; bus.m_addr = 0; bus.m_eret = 0;
  endtask

  task automatic test_reset();
    clear_m();
    bus.cp0_status = 0; bus.cp0_cause = 0; bus.cp0_epc = 0; bus.redirect_ready = 0;
    resetn = 0;
    step(); step();
    n_chk++; if (bus.ex_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ex_valid got %b exp 0", bus.ex_valid); end
    n_chk++; if (bus.flush !== 1'b0 || bus.redirect_valid !== 1'b0) begin n_fail++; $display("FAIL rst_flush_rv got %b%b exp 00", bus.flush, bus.redirect_valid); end
    n_chk++; if (bus.ex_excode !== 5'd0 || bus.ex_epc !== 32'h0 || bus.ex_badvaddr !== 32'h0 || bus.redirect_pc !== 32'h0 || bus.ex_bd !== 1'b0 || bus.ex_eret !== 1'b0)
      begin n_fail++; $display("FAIL rst_regs got code=%0d epc=%h bad=%h rpc=%h exp zeros", bus.ex_excode, bus.ex_epc, bus.ex_badvaddr, bus.redirect_pc); end
    resetn = 1;
    step();
  endtask

  task automatic test_ov();
    bus.cp0_status = 32'h0040_0000; bus.cp0_cause = 0; bus.redirect_ready = 1;
    bus.m_valid = 1; bus.m_ov = 1; bus.m_pc = 32'h8000_1000;
    #1;
    n_chk++; if (bus.flush !== 1'b1) begin n_fail++; $display("FAIL ov_flush_T got %b exp 1", bus.flush); end
    step();
    n_chk++; if (bus.ex_valid !== 1'b1 || bus.ex_excode !== 5'd12) begin n_fail++; $display("FAIL ov_commit got v=%b code=%0d exp v=1 code=12", bus.ex_valid, bus.ex_excode); end
    n_chk++; if (bus.ex_epc !== 32'h8000_1000 || bus.ex_bd !== 1'b0 || bus.ex_badvaddr !== 32'h0) begin n_fail++; $display("FAIL ov_epc got %h bd=%b bad=%h exp 80001000 0 0", bus.ex_epc, bus.ex_bd, bus.ex_badvaddr); end
    n_chk++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'hBFC0_0380) begin n_fail++; $display("FAIL ov_redir got rv=%b pc=%h exp 1 bfc00380", bus.redirect_valid, bus.redirect_pc); end
    clear_m();
    step();
    n_chk++; if (bus.redirect_valid !== 1'b0 || bus.flush !== 1'b0 || bus.ex_valid !== 1'b0) begin n_fail++; $display("FAIL ov_idle got rv=%b fl=%b v=%b exp 000", bus.redirect_valid, bus.flush, bus.ex_valid); end
  endtask

  task automatic test_addr_err();
    bus.cp0_status = 0; bus.redirect_ready = 1;
    bus.m_valid = 1; bus.m_adel_ld = 1; bus.m_addr = 32'h1003; bus.m_bd = 1; bus.m_pc = 32'h8000_2004;
    step();
    n_chk++; if (bus.ex_excode !== 5'd4 || bus.ex_bd !== 1'b1) begin n_fail++; $display("FAIL adel_ld_code got %0d bd=%b exp 4 1", bus.ex_excode, bus.ex_bd); end
    n_chk++; if (bus.ex_epc !== 32'h8000_2000 || bus.ex_badvaddr !== 32'h1003) begin n_fail++; $display("FAIL adel_ld_addr got epc=%h bad=%h exp 80002000 1003", bus.ex_epc, bus.ex_badvaddr); end
    n_chk++; if (bus.redirect_pc !== 32'h8000_0180) begin n_fail++; $display("FAIL adel_ld_vec got %h exp 80000180", bus.redirect_pc); end
    clear_m(); step();
    // fetch error beats overflow; badvaddr comes from pc, epc wraps below zero
    bus.m_valid = 1; bus.m_adel_if = 1; bus.m_ov = 1; bus.m_bd = 1; bus.m_pc = 32'h0; bus.m_addr = 32'h55;
    step();
    n_chk++; if (bus.ex_excode !== 5'd4 || bus.ex_badvaddr !== 32'h0 || bus.ex_epc !== 32'hFFFF_FFFC)
      begin n_fail++; $display("FAIL adel_if_wrap got code=%0d bad=%h epc=%h exp 4 0 fffffffc", bus.ex_excode, bus.ex_badvaddr, bus.ex_epc); end
    clear_m(); step();
    bus.m_valid = 1; bus.m_ades = 1; bus.m_bp = 1; bus.m_addr = 32'h2002; bus.m_pc = 32'h8000_2100;
    step();
    n_chk++; if (bus.ex_excode !== 5'd9 || bus.ex_badvaddr !== 32'h0) begin n_fail++; $display("FAIL bp_over_ades got code=%0d bad=%h exp 9 0", bus.ex_excode, bus.ex_badvaddr); end
    clear_m(); step();
    bus.m_valid = 1; bus.m_ades = 1; bus.m_addr = 32'h2002; bus.m_pc = 32'h8000_2104;
    step();
    n_chk++; if (bus.ex_excode !== 5'd5 || bus.ex_badvaddr !== 32'h2002) begin n_fail++; $display("FAIL ades got code=%0d bad=%h exp 5 2002", bus.ex_excode, bus.ex_badvaddr); end
    clear_m(); step();
  endtask

  task automatic test_int();
    bus.cp0_status = 32'h0000_0401; bus.cp0_cause = 32'h0400; bus.redirect_ready = 1;
    #1;
    n_chk++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL int_wait_flush got %b exp 0", bus.flush); end
    step();
    n_chk++; if (bus.ex_valid !== 1'b0 || bus.redirect_valid !== 1'b0) begin n_fail++; $display("FAIL int_wait_commit got v=%b rv=%b exp 00", bus.ex_valid, bus.redirect_valid); end
    bus.m_valid = 1; bus.m_ri = 1; bus.m_pc = 32'h8000_0040;
    step();
    n_chk++; if (bus.ex_valid !== 1'b1 || bus.ex_excode !== 5'd0 || bus.redirect_pc !== 32'h8000_0180)
      begin n_fail++; $display("FAIL int_wins got v=%b code=%0d rpc=%h exp 1 0 80000180", bus.ex_valid, bus.ex_excode, bus.redirect_pc); end
    clear_m(); step();
    bus.cp0_status = 32'h0000_0403;
    bus.m_valid = 1; bus.m_ri = 1; bus.m_pc = 32'h8000_0044;
    step();
    n_chk++; if (bus.ex_excode !== 5'd10) begin n_fail++; $display("FAIL int_exl_ri got %0d exp 10", bus.ex_excode); end
    clear_m(); bus.cp0_status = 0; bus.cp0_cause = 0; step();
  endtask

  task automatic test_eret();
    bus.cp0_status = 32'h2; bus.cp0_epc = 32'hBFC0_0100; bus.redirect_ready = 1;
    bus.m_valid = 1; bus.m_eret = 1; bus.m_pc = 32'h8000_0200;
    step();
    n_chk++; if (bus.ex_eret !== 1'b1 || bus.ex_excode !== 5'd0 || bus.redirect_pc !== 32'hBFC0_0100)
      begin n_fail++; $display("FAIL eret got er=%b code=%0d rpc=%h exp 1 0 bfc00100", bus.ex_eret, bus.ex_excode, bus.redirect_pc); end
    clear_m(); step();
    bus.m_valid = 1; bus.m_eret = 1; bus.m_sys = 1; bus.m_pc = 32'h8000_0204;
    step();
    n_chk++; if (bus.ex_eret !== 1'b0 || bus.ex_excode !== 5'd8 || bus.redirect_pc !== 32'h8000_0180)
      begin n_fail++; $display("FAIL eret_sys got er=%b code=%0d rpc=%h exp 0 8 80000180", bus.ex_eret, bus.ex_excode, bus.redirect_pc); end
    clear_m(); step();
    bus.cp0_status = 32'h0;
    bus.m_valid = 1; bus.m_eret = 1; bus.m_pc = 32'h8000_0208;
    step();
`ifdef EXC_ERET_CHECK_EN
    n_chk++; if (bus.ex_eret !== 1'b0 || bus.ex_excode !== 5'd10 || bus.redirect_pc !== 32'h8000_0180)
      begin n_fail++; $display("FAIL eret_noexl got er=%b code=%0d rpc=%h exp 0 10 80000180", bus.ex_eret, bus.ex_excode, bus.redirect_pc); end
`else
    n_chk++; if (bus.ex_eret !== 1'b1 || bus.ex_excode !== 5'd0 || bus.redirect_pc !== 32'hBFC0_0100)
      begin n_fail++; $display("FAIL eret_noexl got er=%b code=%0d rpc=%h exp 1 0 bfc00100", bus.ex_eret, bus.ex_excode, bus.redirect_pc); end
`endif
    clear_m(); step();
  endtask

  task automatic test_back_to_back();
    bus.cp0_status = 32'h0040_0000; bus.redirect_ready = 0;
    bus.m_valid = 1; bus.m_ov = 1; bus.m_pc = 32'h8000_3000;
    step();
    n_chk++; if (bus.ex_valid !== 1'b1 || bus.redirect_valid !== 1'b1) begin n_fail++; $display("FAIL stall_T1 got v=%b rv=%b exp 11", bus.ex_valid, bus.redirect_valid); end
    bus.m_ov = 0; bus.m_sys = 1; bus.m_pc = 32'h8000_3004;
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++; if (bus.redirect_valid !== 1'b1 || bus.flush !== 1'b1 || bus.ex_valid !== 1'b0 || bus.redirect_pc !== 32'hBFC0_0380)
        begin n_fail++; $display("FAIL stall_hold%0d got rv=%b fl=%b v=%b rpc=%h exp 1 1 0 bfc00380", i, bus.redirect_valid, bus.flush, bus.ex_valid, bus.redirect_pc); end
      if (i == 2) bus.redirect_ready = 1;
    end
    step();
    n_chk++; if (bus.redirect_valid !== 1'b0 || bus.ex_valid !== 1'b0 || bus.flush !== 1'b1)
      begin n_fail++; $display("FAIL stall_release got rv=%b v=%b fl=%b exp 0 0 1", bus.redirect_valid, bus.ex_valid, bus.flush); end
    step();
    n_chk++; if (bus.ex_valid !== 1'b1 || bus.ex_excode !== 5'd8 || bus.ex_epc !== 32'h8000_3004)
      begin n_fail++; $display("FAIL stall_next got v=%b code=%0d epc=%h exp 1 8 80003004", bus.ex_valid, bus.ex_excode, bus.ex_epc); end
    clear_m(); step();
  endtask

  task automatic test_reset_in_redir();
    bus.cp0_status = 32'h0; bus.redirect_ready = 0;
    bus.m_valid = 1; bus.m_ov = 1; bus.m_pc = 32'h8000_5000;
    step(); clear_m(); step();
    n_chk++; if (bus.redirect_valid !== 1'b1) begin n_fail++; $display("FAIL rr_pre got rv=%b exp 1", bus.redirect_valid); end
    resetn = 0;
    #1;
    n_chk++; if (bus.redirect_valid !== 1'b0 || bus.flush !== 1'b0 || bus.redirect_pc !== 32'h0)
      begin n_fail++; $display("FAIL rr_async got rv=%b fl=%b rpc=%h exp 0 0 0", bus.redirect_valid, bus.flush, bus.redirect_pc); end
    step();
    resetn = 1; bus.redirect_ready = 1;
    bus.m_valid = 1; bus.m_sys = 1; bus.m_pc = 32'h8000_4000;
    #1;
    n_chk++; if (bus.flush !== 1'b1) begin n_fail++; $display("FAIL rr_take got fl=%b exp 1", bus.flush); end
    step();
    n_chk++; if (bus.ex_valid !== 1'b1 || bus.ex_excode !== 5'd8 || bus.ex_epc !== 32'h8000_4000)
      begin n_fail++; $display("FAIL rr_sys got v=%b code=%0d epc=%h exp 1 8 80004000", bus.ex_valid, bus.ex_excode, bus.ex_epc); end
    clear_m(); step();
  endtask

  initial begin
    test_reset();
    test_ov();
    test_addr_err();
    test_int();
    test_eret();
    test_back_to_back();
    test_reset_in_redir();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
